// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: frame FSM states,
// receive-FIFO entry layout and small helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // FIFO entry layout: data occupies [DATA_WIDTH-1:0] from FLD_DATA; the
  // flag offsets below are relative to DATA_WIDTH.
  localparam int unsigned FLD_DATA = 0;
  localparam int unsigned FLD_PERR = 0;
  localparam int unsigned FLD_FERR = 1;
  localparam int unsigned FLD_BRK  = 2;
  localparam int unsigned FLAG_W   = 3;

  // Width of the per-bit oversample tick counter.
  function automatic int unsigned tick_w(input int unsigned oversample);
    return $clog2(oversample);
  endfunction

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Bus bundle between the baud generator / register block and the receiver.
interface uart_rx_cfg_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH + 1);

  logic                  baud_en;
  logic                  rx;
  logic [3:0]            cfg_data_bits;
  logic                  cfg_parity_en;
  logic                  cfg_parity_odd;
  logic                  cfg_stop2;
  logic                  rx_rd;
  logic                  ovr_clr;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_perr;
  logic                  rx_ferr;
  logic                  rx_brk;
  logic                  rx_valid;
  logic [LEVEL_W-1:0]    rx_level;
  logic                  rx_overrun;
  logic                  rx_busy;

  modport master (
    output baud_en, rx, cfg_data_bits, cfg_parity_en, cfg_parity_odd, cfg_stop2,
           rx_rd, ovr_clr,
    input  rx_data, rx_perr, rx_ferr, rx_brk, rx_valid, rx_level, rx_overrun,
           rx_busy
  );

  modport slave (
    input  baud_en, rx, cfg_data_bits, cfg_parity_en, cfg_parity_odd, cfg_stop2,
           rx_rd, ovr_clr,
    output rx_data, rx_perr, rx_ferr, rx_brk, rx_valid, rx_level, rx_overrun,
           rx_busy
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with simultaneous push/pop and
// occupancy output. Pointers carry one extra wrap bit to tell full from empty.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr[AW-1:0]];
  assign level   = LW'(wptr - rptr);

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  // Read/write pointer advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 2-flop synchroniser, 3-sample majority
// frame FSM with parity/framing/break detection, and a FWFT receive FIFO.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  uart_rx_cfg_if.slave bus
);
  localparam int unsigned TW  = tick_w(OVERSAMPLE);
  localparam int unsigned BCW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned EW  = DATA_WIDTH + FLAG_W;
  localparam int unsigned LW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_S2  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

  logic                  rx_s1, rx_s2, rx_prev;
  logic                  fall;
  rx_state_t             state;
  logic [TW-1:0]         tick;
  logic [BCW-1:0]        bit_cnt;
  logic [BCW-1:0]        nbits;
  logic [BCW-1:0]        nbits_cfg;
  logic                  par_en, par_odd, stop2, stop_second;
  logic                  samp_a, samp_b;
  logic                  bit_v;
  logic                  at_s2, at_end;
  logic [DATA_WIDTH-1:0] data_sr;
  logic                  par_acc, seen_one;
  logic                  perr, ferr;
  logic                  busy;
  logic                  wr_en;
  logic [EW-1:0]         wr_entry;
  logic                  overrun;
  logic [EW-1:0]         head;
  logic                  empty, full;
  logic [LW-1:0]         level;

  assign fall   = rx_prev & ~rx_s2;
  assign bit_v  = maj3(samp_a, samp_b, rx_s2);
  assign at_s2  = bus.baud_en && (tick == T_S2);
  assign at_end = bus.baud_en && (tick == T_END);

  // Clamp the requested character length into 5..DATA_WIDTH.
  always_comb begin
    nbits_cfg = BCW'(bus.cfg_data_bits);
    if (32'(bus.cfg_data_bits) < 32'd5) nbits_cfg = BCW'(5);
    else if (32'(bus.cfg_data_bits) > DATA_WIDTH) nbits_cfg = BCW'(DATA_WIDTH);
  end

  // Two-flop synchroniser plus previous-value flop for start-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= bus.rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Frame FSM: bit timing, sampling, field checks and the registered FIFO write.
  // Bits are voted at tick M+1 and advanced at the last tick, except the final
  // stop bit which finishes at M+1 so the next start edge is never missed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      tick        <= '0;
      bit_cnt     <= '0;
      nbits       <= '0;
      par_en      <= 1'b0;
      par_odd     <= 1'b0;
      stop2       <= 1'b0;
      stop_second <= 1'b0;
      samp_a      <= 1'b1;
      samp_b      <= 1'b1;
      data_sr     <= '0;
      par_acc     <= 1'b0;
      seen_one    <= 1'b0;
      perr        <= 1'b0;
      ferr        <= 1'b0;
      busy        <= 1'b0;
      wr_en       <= 1'b0;
      wr_entry    <= '0;
    end else begin
      wr_en <= 1'b0;
      if (state != ST_IDLE && bus.baud_en) begin
        if (tick == T_END) tick <= '0;
        else               tick <= tick + 1'b1;
        if (tick == T_S0) samp_a <= rx_s2;
        if (tick == T_S1) samp_b <= rx_s2;
      end
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state       <= ST_START;
            busy        <= 1'b1;
            tick        <= '0;
            bit_cnt     <= '0;
            nbits       <= nbits_cfg;
            par_en      <= bus.cfg_parity_en;
            par_odd     <= bus.cfg_parity_odd;
            stop2       <= bus.cfg_stop2;
            stop_second <= 1'b0;
            data_sr     <= '0;
            par_acc     <= 1'b0;
            seen_one    <= 1'b0;
            perr        <= 1'b0;
            ferr        <= 1'b0;
          end
        end
        ST_START: begin
          if (at_s2 && bit_v) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (at_end) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (at_s2) begin
            data_sr  <= data_sr | (DATA_WIDTH'(bit_v) << bit_cnt);
            par_acc  <= par_acc ^ bit_v;
            seen_one <= seen_one | bit_v;
          end
          if (at_end) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == nbits - BCW'(1)) state <= par_en ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (at_s2) begin
            perr     <= bit_v != (par_acc ^ par_odd);
            seen_one <= seen_one | bit_v;
          end
          if (at_end) state <= ST_STOP;
        end
        ST_STOP: begin
          if (at_s2) begin
            if (stop2 && !stop_second) begin
              if (!bit_v) ferr <= 1'b1;
            end else begin
              state                            <= ST_IDLE;
              busy                             <= 1'b0;
              wr_en                            <= 1'b1;
              wr_entry[FLD_DATA +: DATA_WIDTH] <= data_sr;
              wr_entry[DATA_WIDTH + FLD_PERR]  <= perr;
              wr_entry[DATA_WIDTH + FLD_FERR]  <= ferr | ~bit_v;
              wr_entry[DATA_WIDTH + FLD_BRK]   <= ~seen_one & ~bit_v;
            end
          end
          if (at_end) stop_second <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun: a write into a full FIFO with no same-cycle pop; set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              overrun <= 1'b0;
    else if (wr_en && full && !bus.rx_rd) overrun <= 1'b1;
    else if (bus.ovr_clr)                 overrun <= 1'b0;
  end

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (bus.rx_rd),
    .din   (wr_entry),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .level (level)
  );

  assign bus.rx_valid   = ~empty;
  assign bus.rx_data    = empty ? '0 : head[FLD_DATA +: DATA_WIDTH];
  assign bus.rx_perr    = ~empty & head[DATA_WIDTH + FLD_PERR];
  assign bus.rx_ferr    = ~empty & head[DATA_WIDTH + FLD_FERR];
  assign bus.rx_brk     = ~empty & head[DATA_WIDTH + FLD_BRK];
  assign bus.rx_level   = level;
  assign bus.rx_overrun = overrun;
  assign bus.rx_busy    = busy;
endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Runtime-configurable UART receiver that succeeds the fixed 8-bit even-parity receiver. It takes the same 16x (parameterisable) oversampling enable from the baud generator and adds:
- selectable data length, parity mode and stop-bit count;
- 3-sample majority voting;
- framing, parity, break and overrun reporting;
- a first-word-fall-through receive FIFO.

It sits between the baud generator and the APB register block, which pops received characters.

## Interface
- DATA_WIDTH, 8: maximum data bits per character (≥5)
- OVERSAMPLE, 16: baud_en ticks per bit (even, ≥8)
- FIFO_DEPTH, 4: receive FIFO entries (power of two, ≥2)
- clk  in  1  single clock; one clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- baud_en  in  1  one-cycle oversample tick
- rx  in  1  serial line, asynchronous, idle high
- cfg_data_bits  in  4  data bits per character
- cfg_parity_en  in  1  parity bit present
- cfg_parity_odd  in  1  odd parity when 1, even when 0
- cfg_stop2  in  1  two stop bits when 1
- rx_rd  in  1  pop FIFO head
- ovr_clr  in  1  clear sticky overrun
- rx_data  out  DATA_WIDTH  FIFO head data, LSB = first bit received
- rx_perr  out  1  head parity error
- rx_ferr  out  1  head framing error
- rx_brk  out  1  head is a break
- rx_valid  out  1  FIFO not empty
- rx_level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
- rx_overrun  out  1  sticky: a character was dropped
- rx_busy  out  1  frame in progress

## Operation
- **Synchroniser:** rx passes through 2 flops, which reset to 1. Start is detected on a 1→0 transition of the synchronised line, so a held-low line never retriggers.
- **FSM states:**
  - IDLE → START on falling edge.
  - START → DATA if start majority = 0; START → IDLE (false start, nothing written) if majority = 1.
  - DATA → PARITY after cfg_data_bits bits, or → STOP if parity is disabled.
  - PARITY → STOP.
  - STOP → IDLE.
- **Config latching:** config is latched at the start edge; changes mid-frame are ignored. cfg_data_bits < 5 is treated as 5; > DATA_WIDTH is treated as DATA_WIDTH.
- **Bit timing:** tick counter runs 0..OVERSAMPLE-1 per bit, starting at 0 on the start edge. Samples are taken at ticks M-1, M, M+1 (M = OVERSAMPLE/2); bit value = majority of the three. A bit ends at tick OVERSAMPLE-1.
- **Data bits:** shifted LSB-first. Unused upper bits are written as 0.
- **Parity check:**
  - Expected even-parity bit = XOR of the received data bits; odd parity = its inverse.
  - A mismatch sets perr.
- **Stop bits:**
  - The final stop bit is evaluated at tick M+1, then the FSM goes to IDLE immediately; this allows back-to-back frames.
  - With cfg_stop2, the first stop bit runs its full period.
  - Any stop majority of 0 sets ferr.
- **Break:** all data bits 0, parity bit 0 (if enabled) and final stop bit 0 → brk = 1, with ferr also 1.
- **Write:** on leaving STOP, {brk, ferr, perr, data} is written to the FIFO.
  - If the FIFO is full and rx_rd is not asserted in the same cycle, the character is dropped and rx_overrun is set.
  - If full and rx_rd is asserted in the same cycle, the pop and push both occur and there is no overrun.
- **Overrun clear:** rx_overrun clears on ovr_clr. If ovr_clr and a new overrun coincide, set wins.
- **Pop:** rx_rd while empty is ignored. rx_data and the flags show the head entry whenever rx_valid = 1.
- **Busy:** rx_busy is high from START through STOP, and low in IDLE.

## Timing
- **Reset:** all outputs 0, FSM IDLE, FIFO empty, tick and bit counters 0, synchronisers 1. Reset mid-frame aborts the frame; nothing is written.
- **Start detection:** start edge on rx reaches the FSM 2 cycles later (synchroniser). rx_busy rises the cycle after detection.
- **Write latency:** the FIFO write is registered. rx_valid and rx_level update 1 cycle after the final-stop tick (M+1).
- **Pop latency:** rx_rd with rx_valid advances the head; new head data and rx_level are visible the next cycle.
- **Empty → non-empty:** no combinational path from rx_rd to rx_valid.
- **Wrap-around:** FIFO pointers are $clog2(FIFO_DEPTH)+1 bits; full = MSBs differ with the rest equal.

## Structure
- Package uart_pkg:
  - FSM state encoding localparams;
  - FIFO entry field offsets (DATA, PERR, FERR, BRK);
  - majority-of-3 function;
  - tick-counter width $clog2(OVERSAMPLE).
- Sub-module uart_rx_fifo: parameterised sync FIFO (WIDTH, DEPTH) with FWFT head, simultaneous push/pop, level output. The frame FSM stays in uart_rx_cfg.

## Test plan
- 8N1, byte 0xA5 → after 10 bit periods: rx_valid = 1, rx_data = 0xA5, all flags 0, rx_level = 1; rx_rd → rx_valid = 0 next cycle.
- 7O2, byte 0x3C sent with wrong parity bit 0 → rx_data = 0x3C, rx_perr = 1, rx_ferr = 0; the second stop bit's full period is honoured.
- 8E1: 0x00 with parity 0 and stop 0 → rx_brk = 1, rx_ferr = 1, rx_data = 0x00. Line held low for 3 more frame times → no further writes.
- rx low for 5 ticks then high (false start) → rx_busy pulses, FIFO stays empty. A single-tick glitch at tick M during a data bit is rejected by majority vote.
- FIFO_DEPTH = 4, 5 frames 0x01..0x05 with no reads → rx_level = 4, rx_overrun = 1, pops return 0x01..0x04. ovr_clr → rx_overrun = 0.
- rst asserted mid-DATA → outputs 0 within the reset cycle. A following 0x5A frame is received correctly.
